// File: rtl/dmem_be.sv
// Byte-addressable data memory with byte/half/word access, load extension,
// selectable combinational or registered read, and a sticky misalignment flag.
module dmem_be #(
    parameter int          ADDR_W    = 6,
    parameter int          READ_LAT  = 0,
    parameter logic [31:0] INIT_FILL = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] dIn,
    input  logic        errClr,
    output logic [31:0] dOut,
    output logic        rvalid,
    output logic        misalign,
    output logic [31:0] errAddr
);
    localparam int DEPTH = 1 << ADDR_W;

    // Contents survive reset; the fill value exists only at power-up.
    logic [31:0] mem [DEPTH] = '{default: INIT_FILL};

    logic [ADDR_W-1:0] idx;
    logic              legal;
    logic              is_load;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       ld_data;

    assign idx     = addr[ADDR_W+1:2];
    assign is_load = req & ~we;
    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        legal = 1'b0;
        case (size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~addr[0];
            2'b10:   legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be    = 4'b0000;
        wdata = dIn;
        case (size)
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{dIn[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{dIn[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && req && we && legal) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        ld_data = '0;
        if (legal) begin
            case (size)
                2'b00:   ld_data = {{24{sign & rd_byte[7]}}, rd_byte};
                2'b01:   ld_data = {{16{sign & rd_half[15]}}, rd_half};
                2'b10:   ld_data = rd_word;
                default: ld_data = '0;
            endcase
        end
    end

    // rvalid: one pulse per load, no back-pressure; dOut is meaningful only
    // while rvalid=1 (same cycle when combinational, next cycle when registered).
    generate
        if (READ_LAT == 0) begin : g_comb
            assign dOut   = (is_load && !reset) ? ld_data : '0;
            assign rvalid = is_load & ~reset;
        end else begin : g_reg
            logic [31:0] dout_q;
            logic        rvalid_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q   <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= is_load;
                    if (is_load) dout_q <= ld_data;
                end
            end

            assign dOut   = dout_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

    // A new violation beats a same-cycle clear; otherwise the first address sticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign <= 1'b0;
            errAddr  <= '0;
        end else if (req && !legal && (!misalign || errClr)) begin
            misalign <= 1'b1;
            errAddr  <= addr;
        end else if (errClr) begin
            misalign <= 1'b0;
            errAddr  <= '0;
        end
    end
endmodule
